// File: rtl/forward_unit.sv
// Operand-forwarding and load-use hazard unit for a 5-stage pipeline.
// Tracks EX/MEM and MEM/WB destinations and drives EX operand-mux selects and the ID stall.
module forward_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] ex_rs,
  input  logic [REG_BITS-1:0] ex_rt,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                pipe_hold,
  input  logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall_id,
  output logic [CNT_BITS-1:0] stall_count
);

  // Mux input ordering is fixed by the EX-stage datapath wiring.
  localparam logic [1:0] SEL_EXMEM = 2'b00;
  localparam logic [1:0] SEL_RF    = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  logic [REG_BITS-1:0] exmem_rd_q, exmem_rd_d;
  logic                exmem_we_q, exmem_we_d;
  logic                exmem_ld_q, exmem_ld_d;
  logic [REG_BITS-1:0] memwb_rd_q, memwb_rd_d;
  logic                memwb_we_q, memwb_we_d;
  logic [CNT_BITS-1:0] stall_count_q, stall_count_d;

  logic exmem_fwd_ok;
  logic memwb_fwd_ok;

  // A load sitting in EX/MEM has no data yet, so it is never a forward source.
  assign exmem_fwd_ok = exmem_we_q & ~exmem_ld_q & (exmem_rd_q != '0);
  assign memwb_fwd_ok = memwb_we_q & (memwb_rd_q != '0);

  always_comb begin
    fwd_a = SEL_RF;
    if (exmem_fwd_ok && exmem_rd_q == ex_rs)      fwd_a = SEL_EXMEM;
    else if (memwb_fwd_ok && memwb_rd_q == ex_rs) fwd_a = SEL_MEMWB;
  end

  always_comb begin
    fwd_b = SEL_RF;
    if (exmem_fwd_ok && exmem_rd_q == ex_rt)      fwd_b = SEL_EXMEM;
    else if (memwb_fwd_ok && memwb_rd_q == ex_rt) fwd_b = SEL_MEMWB;
  end

  assign stall_id = ex_mem_read & ex_reg_write & ~flush & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    exmem_rd_d    = exmem_rd_q;
    exmem_we_d    = exmem_we_q;
    exmem_ld_d    = exmem_ld_q;
    memwb_rd_d    = memwb_rd_q;
    memwb_we_d    = memwb_we_q;
    stall_count_d = stall_count_q;
    if (!pipe_hold) begin
      exmem_rd_d = ex_rd;
      exmem_we_d = ex_reg_write & ~flush;
      exmem_ld_d = ex_mem_read & ~flush;
      memwb_rd_d = exmem_rd_q;
      memwb_we_d = exmem_we_q;
      if (stall_id) stall_count_d = stall_count_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_rd_q    <= '0;
      exmem_we_q    <= 1'b0;
      exmem_ld_q    <= 1'b0;
      memwb_rd_q    <= '0;
      memwb_we_q    <= 1'b0;
      stall_count_q <= '0;
    end else begin
      exmem_rd_q    <= exmem_rd_d;
      exmem_we_q    <= exmem_we_d;
      exmem_ld_q    <= exmem_ld_d;
      memwb_rd_q    <= memwb_rd_d;
      memwb_we_q    <= memwb_we_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_unit.sv
// Bench for forward_unit: directed hazard scenarios plus randomized traffic,
// all outputs compared each cycle against a producer-list model of the pipeline.
module tb_forward_unit;
  localparam int RB = 5;
  localparam int CB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [RB-1:0] ex_rs, ex_rt, ex_rd, id_rs, id_rt;
  logic          ex_reg_write, ex_mem_read, id_uses_rt, pipe_hold, flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_id;
  logic [CB-1:0] stall_count;

  always #5 clk = ~clk;

  forward_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .pipe_hold(pipe_hold), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_id(stall_id), .stall_count(stall_count)
  );

  // Model: list of older producers, index 0 = newest (EX/MEM), 1 = MEM/WB.
  typedef struct {
    logic [RB-1:0] rd;
    logic          we;
    logic          ld;
  } stage_t;

  stage_t        pipe_q[$];
  logic [CB-1:0] m_count;
  int            total = 0;
  int            bad = 0;
  bit            cmp_en = 0;

  function automatic logic [1:0] m_fwd(input logic [RB-1:0] src);
    if (pipe_q.size() < 2 || src == 0) return 2'b01;
    if (pipe_q[0].we && !pipe_q[0].ld && pipe_q[0].rd == src) return 2'b00;
    if (pipe_q[1].we && pipe_q[1].rd == src) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic m_stall();
    return ex_mem_read && ex_reg_write && !flush && ex_rd != 0 &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  endfunction

  always @(posedge clk or posedge rst) begin
    stage_t s;
    if (rst) begin
      pipe_q.delete();
      s.rd = '0; s.we = 1'b0; s.ld = 1'b0;
      pipe_q.push_back(s);
      pipe_q.push_back(s);
      m_count = '0;
    end else if (!pipe_hold) begin
      if (m_stall()) m_count = m_count + 1;
      s.rd = ex_rd;
      s.we = ex_reg_write && !flush;
      s.ld = ex_mem_read && !flush;
      pipe_q.push_front(s);
      void'(pipe_q.pop_back());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_fwd_a", {30'd0, fwd_a}, {30'd0, m_fwd(ex_rs)});
      chk("model_fwd_b", {30'd0, fwd_b}, {30'd0, m_fwd(ex_rt)});
      chk("model_stall_id", {31'd0, stall_id}, {31'd0, m_stall()});
      chk("model_stall_count", stall_count, m_count);
    end
  end

  task automatic idle();
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    cmp_en = 1;
    at_neg();
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd1);
    chk("rst_stall", {31'd0, stall_id}, 32'd0);
    chk("rst_count", stall_count, 32'd0);
    tick();
    rst = 1'b0;
    at_neg();
    chk("post_rst_fwd_a", {30'd0, fwd_a}, 32'd1);
    tick();

    // back-to-back ALU ops on r5
    idle(); ex_rd = 5; ex_reg_write = 1; tick();
    idle(); ex_rs = 5; at_neg(); chk("b2b_exmem", {30'd0, fwd_a}, 32'd0); tick();
    idle(); ex_rt = 5; at_neg(); chk("b2b_memwb", {30'd0, fwd_b}, 32'd2); tick();

    // both stages write r7: newest wins; r0 never forwards
    idle(); ex_rd = 7; ex_reg_write = 1; tick(); tick();
    idle(); ex_rs = 7; at_neg();
    chk("double_a", {30'd0, fwd_a}, 32'd0);
    chk("double_b_rf", {30'd0, fwd_b}, 32'd1);
    tick();
    idle(); ex_rd = 0; ex_reg_write = 1; tick(); tick();
    idle(); at_neg(); chk("r0_no_fwd", {30'd0, fwd_a}, 32'd1); tick();

    // load-use on r4
    idle(); ex_rd = 4; ex_reg_write = 1; ex_mem_read = 1; id_rs = 4; at_neg();
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    chk("lu_count0", stall_count, 32'd0);
    tick();
    idle(); ex_rs = 4; at_neg();
    chk("lu_count1", stall_count, 32'd1);
    chk("lu_no_ld_fwd", {30'd0, fwd_a}, 32'd1);
    tick();
    idle(); ex_rs = 4; at_neg(); chk("lu_memwb", {30'd0, fwd_a}, 32'd2); tick();
    idle(); ex_rd = 4; ex_reg_write = 1; ex_mem_read = 1; id_rs = 1; id_rt = 4; at_neg();
    chk("lu_rt_unused", {31'd0, stall_id}, 32'd0);
    id_uses_rt = 1; #1;
    chk("lu_rt_used", {31'd0, stall_id}, 32'd1);
    tick();

    // flush
    idle(); ex_rd = 9; ex_reg_write = 1; flush = 1; tick();
    idle(); ex_rs = 9; at_neg(); chk("flush_no_fwd", {30'd0, fwd_a}, 32'd1); tick();
    idle(); ex_rd = 4; ex_reg_write = 1; ex_mem_read = 1; flush = 1; id_rs = 4; at_neg();
    chk("flush_no_stall", {31'd0, stall_id}, 32'd0);
    tick();

    // hold after a write to r2, with a would-be stall and new write held off
    idle(); ex_rd = 2; ex_reg_write = 1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); pipe_hold = 1; ex_rs = 2; ex_rt = 2; ex_rd = 6; ex_reg_write = 1;
      ex_mem_read = 1; id_rs = 6; flush = 1'(i == 1); at_neg();
      chk("hold_fwd_a", {30'd0, fwd_a}, 32'd0);
      chk("hold_fwd_b", {30'd0, fwd_b}, 32'd0);
      chk("hold_count", stall_count, 32'd2);
      tick();
    end
    idle(); ex_rs = 2; at_neg(); chk("release_exmem", {30'd0, fwd_a}, 32'd0); tick();
    idle(); ex_rs = 2; at_neg(); chk("release_memwb", {30'd0, fwd_a}, 32'd2); tick();

    // asynchronous reset mid-operation
    idle(); ex_rd = 3; ex_reg_write = 1; tick(); tick();
    idle(); ex_rs = 3; ex_rt = 3; at_neg();
    chk("pre_rst_fwd", {30'd0, fwd_a}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("midrst_fwd_b", {30'd0, fwd_b}, 32'd1);
    chk("midrst_count", stall_count, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      ex_rs = RB'($urandom_range(0, 7));
      ex_rt = RB'($urandom_range(0, 7));
      ex_rd = RB'($urandom_range(0, 7));
      id_rs = RB'($urandom_range(0, 7));
      id_rt = RB'($urandom_range(0, 7));
      ex_reg_write = 1'($urandom_range(0, 3) != 0);
      ex_mem_read = 1'($urandom_range(0, 2) == 0);
      id_uses_rt = 1'($urandom_range(0, 1));
      pipe_hold = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      rst = 1'($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    cmp_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
